// File: rtl/spm_pkg.sv
// Shared constants for the SPM responder: geometry, bus encodings and sequencer state codes.
package spm_pkg;

  localparam int SPM_DEPTH   = 4096;
  localparam int SPM_ADDR_W  = 12;
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  // Bus direction and active-low strobe encodings shared with the CPU side.
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [0:0] SPM_ST_CLEAR = 1'b0;
  localparam logic [0:0] SPM_ST_READY = 1'b1;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

endpackage

// File: rtl/spm_ram.sv
// Scratchpad word array: one synchronous write port shared by the clear sweep and port M,
// and two combinational read ports. The array itself is never reset.
module spm_ram
  import spm_pkg::*;
#(
  parameter int DEPTH  = SPM_DEPTH,
  parameter int ADDR_W = SPM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic                   m_we,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [WORD_DATA_W-1:0] m_wdata,
  input  logic [ADDR_W-1:0]      raddr_a,
  output logic [WORD_DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0]      raddr_b,
  output logic [WORD_DATA_W-1:0] rdata_b
);

  logic [WORD_DATA_W-1:0] mem [DEPTH];
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [WORD_DATA_W-1:0] wdata;

  // The sweep owns the write port whenever it runs; port M is masked upstream anyway.
  always_comb begin
    we    = clr_en | m_we;
    waddr = clr_en ? clr_addr : m_addr;
    wdata = clr_en ? '0 : m_wdata;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/spm_responder.sv
// SPM bus responder: clear sequencer after reset, then zero-wait-state load/store on port M
// and fetch reads on port I, with write-first bypass when both touch the same word.
module spm_responder
  import spm_pkg::*;
#(
  parameter int DEPTH  = SPM_DEPTH,
  parameter int ADDR_W = SPM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_ADDR_W-1:0] spm_addr,
  input  logic                   spm_as_,
  input  logic                   spm_rw,
  input  logic [WORD_DATA_W-1:0] spm_wr_data,
  output logic [WORD_DATA_W-1:0] spm_rd_data,
  input  logic [WORD_ADDR_W-1:0] if_spm_addr,
  input  logic                   if_spm_as_,
  output logic [WORD_DATA_W-1:0] if_spm_rd_data,
  output logic                   spm_busy
);

  logic [0:0]             state;
  logic [ADDR_W-1:0]      clr_idx;
  logic                   ready;
  logic [ADDR_W-1:0]      m_idx;
  logic [ADDR_W-1:0]      i_idx;
  logic                   m_rd;
  logic                   m_wr;
  logic                   i_rd;
  logic [WORD_DATA_W-1:0] ram_a;
  logic [WORD_DATA_W-1:0] ram_b;
  logic                   unused_addr_bits;

  // Upper word-address bits are deliberately ignored so addresses alias modulo DEPTH.
  assign m_idx            = spm_addr[ADDR_W-1:0];
  assign i_idx            = if_spm_addr[ADDR_W-1:0];
  assign unused_addr_bits = ^{spm_addr[WORD_ADDR_W-1:ADDR_W], if_spm_addr[WORD_ADDR_W-1:ADDR_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SPM_ST_CLEAR;
      clr_idx <= '0;
    end else if (state == SPM_ST_CLEAR) begin
      if (clr_idx == ADDR_W'(DEPTH - 1)) begin
        state <= SPM_ST_READY;
      end
      clr_idx <= clr_idx + ADDR_W'(1);
    end
  end

  assign ready    = (state == SPM_ST_READY);
  assign spm_busy = (state == SPM_ST_CLEAR);

  always_comb begin
    m_rd = ready && (spm_as_ == ENABLE_) && (spm_rw == READ);
    m_wr = ready && (spm_as_ == ENABLE_) && (spm_rw == WRITE);
    i_rd = ready && (if_spm_as_ == ENABLE_);
  end

  spm_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .clr_en   (spm_busy),
    .clr_addr (clr_idx),
    .m_we     (m_wr),
    .m_addr   (m_idx),
    .m_wdata  (spm_wr_data),
    .raddr_a  (m_idx),
    .rdata_a  (ram_a),
    .raddr_b  (i_idx),
    .rdata_b  (ram_b)
  );

  // Fetch sees the store data when it lands on the same word in the same cycle.
  always_comb begin
    spm_rd_data    = '0;
    if_spm_rd_data = '0;
    if (m_rd) begin
      spm_rd_data = ram_a;
    end
    if (i_rd) begin
      if (m_wr && (m_idx == i_idx)) begin
        if_spm_rd_data = spm_wr_data;
      end else begin
        if_spm_rd_data = ram_b;
      end
    end
  end

endmodule
